// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
//   Writer side of the instruction memory. Assembles UART bytes into
//   NB_DATA-bit words (first byte lands in the MSBs). Each word goes to
//   consecutive addresses starting at 0. The fetch stage stays stalled until
//   a HALT word has been written or the memory is full.
//
// Ports
//   i_clock       system clock
//   i_reset       synchronous, active-high reset
//   i_rx_data     received byte, qualified by i_rx_valid
//   i_rx_valid    one-cycle strobe per received byte
//   i_restart     in DONE: clear counters and accept a new program
//   o_wr_en       one-cycle instruction-memory write strobe
//   o_wr_addr     word address of the write (held between writes)
//   o_wr_data     assembled word (held between writes)
//   o_word_count  words written so far, HALT included, saturating
//   o_loading     high while a load is in progress (RECEIVE / WRITE)
//   o_load_done   high in DONE
//   o_overflow    sticky: memory filled without a HALT word
// ----------------------------------------------------------------------------
module instruction_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_restart,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic [NB_ADDR:0]   o_word_count,
  output logic               o_loading,
  output logic               o_load_done,
  output logic               o_overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_ONE   = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_MAX   = {1'b1, {NB_ADDR{1'b0}}};

  logic [1:0]         r_state;
  logic [1:0]         r_byte_idx;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_shift;
  logic               r_wr_en;
  logic [NB_ADDR-1:0] r_wr_addr;
  logic [NB_DATA-1:0] r_wr_data;
  logic [NB_ADDR:0]   r_word_count;
  logic               r_loading;
  logic               r_load_done;
  logic               r_overflow;

  logic [NB_DATA-1:0] w_word;
  logic               w_last_byte;
  logic               w_last_addr;
  logic               w_halt;

  // Shift-left assembly: after four bytes the first one sits in the MSBs.
  assign w_word      = {r_shift[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_addr = (r_addr == LAST_ADDR);
  // r_wr_data holds the word being written during the WRITE cycle.
  assign w_halt      = (r_wr_data == HALT_WORD);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_byte_idx   <= 2'd0;
      r_addr       <= '0;
      r_shift      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_loading    <= 1'b0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            r_shift    <= w_word;
            r_byte_idx <= 2'd1;
            r_loading  <= 1'b1;
            r_state    <= ST_RECEIVE;
          end
        end

        ST_RECEIVE: begin
          if (i_rx_valid) begin
            r_shift    <= w_word;
            r_byte_idx <= r_byte_idx + 2'd1;   // wraps to 0 after byte 3
            if (w_last_byte) begin
              // Register the write now so o_wr_en is high during WRITE.
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_word;
              if (r_word_count != CNT_MAX)
                r_word_count <= r_word_count + CNT_ONE;
            end
          end
        end

        ST_WRITE: begin
          if (w_halt || w_last_addr) begin
            // A byte arriving in this cycle is intentionally dropped.
            r_state     <= ST_DONE;
            r_loading   <= 1'b0;
            r_load_done <= 1'b1;
            r_overflow  <= !w_halt;
            r_byte_idx  <= 2'd0;
          end else begin
            r_addr  <= r_addr + ADDR_ONE;
            r_state <= ST_RECEIVE;
            // Keep full-rate streams lossless: this byte starts the next word.
            if (i_rx_valid) begin
              r_shift    <= w_word;
              r_byte_idx <= 2'd1;
            end
          end
        end

        ST_DONE: begin
          if (i_restart) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_byte_idx   <= 2'd0;
            r_shift      <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_load_done  <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_word_count = r_word_count;
  assign o_loading    = r_loading;
  assign o_load_done  = r_load_done;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_instruction_loader.sv
// ----------------------------------------------------------------------------
// tb_instruction_loader
//   Directed bench. dut1 uses the default 256-word memory, dut2 a 4-word
//   memory for the full-memory cases. Both share the byte stream and restart;
//   each has its own reset so only one is active at a time. Write strobes are
//   collected at the negative edge and compared against hand-computed tables.
// ----------------------------------------------------------------------------
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        restart;

  logic        wr1, wr2;
  logic [7:0]  a1;
  logic [1:0]  a2;
  logic [31:0] d1, d2;
  logic [8:0]  cnt1;
  logic [2:0]  cnt2;
  logic        ld1, ld2, dn1, dn2, ov1, ov2;

  always #5 clk = ~clk;

  instruction_loader #(.NB_ADDR(8)) dut1 (
    .i_clock(clk), .i_reset(rst1), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_restart(restart), .o_wr_en(wr1), .o_wr_addr(a1), .o_wr_data(d1),
    .o_word_count(cnt1), .o_loading(ld1), .o_load_done(dn1), .o_overflow(ov1));

  instruction_loader #(.NB_ADDR(2)) dut2 (
    .i_clock(clk), .i_reset(rst2), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_restart(restart), .o_wr_en(wr2), .o_wr_addr(a2), .o_wr_data(d2),
    .o_word_count(cnt2), .o_loading(ld2), .o_load_done(dn2), .o_overflow(ov2));

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] word;
    int          idle;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  wr_t q1[$];
  wr_t q2[$];
  int  ecyc[$];
  int  cyc = 0;
  int  last_cyc = 0;
  int  npass = 0;
  int  ntot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr1) q1.push_back('{a1, d1, cyc});
    if (wr2) q2.push_back('{{6'd0, a2}, d2, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic chk_wr(input bit sel, input int idx, input logic [7:0] ea,
                        input logic [31:0] ed);
    wr_t w;
    int  sz;
    sz = sel ? q2.size() : q1.size();
    if (idx >= sz) begin
      ntot++;
      $display("FAIL write[%0d]: missing, only %0d writes seen", idx, sz);
    end else begin
      w = sel ? q2[idx] : q1[idx];
      chk($sformatf("wr_addr[%0d]", idx), 64'(w.addr), 64'(ea));
      chk($sformatf("wr_data[%0d]", idx), 64'(w.data), 64'(ed));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
    tick(idle);
  endtask

  task automatic send_word(input logic [31:0] w, input int idle);
    send(w[31:24], idle);
    send(w[23:16], idle);
    send(w[15:8],  idle);
    send(w[7:0],   idle);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"spaced0", 32'h20010005, 16, 8'd0, 32'h20010005};
    tbl[1] = '{"spaced1", 32'hFFFFFFFF, 16, 8'd1, 32'hFFFFFFFF};
    tbl[2] = '{"b2b0",    32'h00010203, 0,  8'd0, 32'h00010203};
    tbl[3] = '{"b2b1",    32'h04050607, 0,  8'd1, 32'h04050607};
    tbl[4] = '{"b2b2",    32'h08090A0B, 0,  8'd2, 32'h08090A0B};
    tbl[5] = '{"b2b3",    32'hFFFFFFFF, 0,  8'd3, 32'hFFFFFFFF};

    rst1 = 1'b1; rst2 = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
    tick(5);
    chk("rst wr_en",  64'({wr1, wr2}), 64'd0);
    chk("rst addr",   64'({a1, a2}), 64'd0);
    chk("rst data",   64'({d1, d2}), 64'd0);
    chk("rst count",  64'({cnt1, cnt2}), 64'd0);
    chk("rst flags",  64'({ld1, dn1, ov1, ld2, dn2, ov2}), 64'd0);

    rst1 = 1'b0; rst2 = 1'b0;
    tick(20);
    chk("idle no writes", 64'(q1.size() + q2.size()), 64'd0);
    chk("idle loading", 64'(ld1), 64'd0);
    rst2 = 1'b1;

    // Spaced bytes, 16 idle cycles apart.
    q1.delete(); ecyc.delete();
    for (int i = 0; i < 2; i++) begin
      send_word(tbl[i].word, tbl[i].idle);
      ecyc.push_back(last_cyc + 1);
      if (i == 0) chk("spaced loading mid", 64'(ld1), 64'd1);
    end
    chk("spaced nwrites", 64'(q1.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      chk_wr(1'b0, i, tbl[i].exp_addr, tbl[i].exp_data);
      if (i < q1.size()) chk({tbl[i].name, " latency"}, 64'(q1[i].cyc), 64'(ecyc[i]));
    end
    chk("spaced count",    64'(cnt1), 64'd2);
    chk("spaced done",     64'(dn1), 64'd1);
    chk("spaced loading",  64'(ld1), 64'd0);
    chk("spaced overflow", 64'(ov1), 64'd0);

    // Full-rate stream: bytes landing in WRITE cycles must not be lost.
    rst1 = 1'b1; tick(1); rst1 = 1'b0;
    q1.delete(); ecyc.delete();
    for (int i = 2; i < 6; i++) begin
      send_word(tbl[i].word, tbl[i].idle);
      ecyc.push_back(last_cyc + 1);
    end
    tick(4);
    chk("b2b nwrites", 64'(q1.size()), 64'd4);
    for (int i = 2; i < 6; i++) begin
      chk_wr(1'b0, i - 2, tbl[i].exp_addr, tbl[i].exp_data);
      if (i - 2 < q1.size())
        chk({tbl[i].name, " latency"}, 64'(q1[i-2].cyc), 64'(ecyc[i-2]));
    end
    chk("b2b count", 64'(cnt1), 64'd4);
    chk("b2b done",  64'(dn1), 64'd1);

    // 4-word memory filled without HALT, then extra bytes.
    rst1 = 1'b1; rst2 = 1'b0;
    q2.delete();
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_word(32'h44444444, 0);
    send_word(32'h55667788, 1);
    tick(4);
    chk("ovf nwrites", 64'(q2.size()), 64'd4);
    chk_wr(1'b1, 0, 8'd0, 32'h11111111);
    chk_wr(1'b1, 1, 8'd1, 32'h22222222);
    chk_wr(1'b1, 2, 8'd2, 32'h33333333);
    chk_wr(1'b1, 3, 8'd3, 32'h44444444);
    chk("ovf done",     64'(dn2), 64'd1);
    chk("ovf overflow", 64'(ov2), 64'd1);
    chk("ovf count",    64'(cnt2), 64'd4);
    chk("ovf loading",  64'(ld2), 64'd0);

    // HALT in the last slot: done without overflow.
    rst2 = 1'b1; tick(1); rst2 = 1'b0;
    q2.delete();
    send_word(32'h01020304, 1);
    send_word(32'h05060708, 1);
    send_word(32'h090A0B0C, 1);
    send_word(32'hFFFFFFFF, 1);
    tick(4);
    chk("lasthalt nwrites", 64'(q2.size()), 64'd4);
    chk_wr(1'b1, 3, 8'd3, 32'hFFFFFFFF);
    chk("lasthalt done",     64'(dn2), 64'd1);
    chk("lasthalt overflow", 64'(ov2), 64'd0);
    chk("lasthalt count",    64'(cnt2), 64'd4);
    rst2 = 1'b1;

    // Reset mid-word discards the partial word.
    rst1 = 1'b0; tick(1);
    q1.delete();
    send(8'hAA, 2);
    send(8'hBB, 2);
    rst1 = 1'b1; tick(1); rst1 = 1'b0;
    send_word(32'h11223344, 2);
    tick(3);
    chk("midrst nwrites", 64'(q1.size()), 64'd1);
    chk_wr(1'b0, 0, 8'd0, 32'h11223344);
    chk("midrst loading", 64'(ld1), 64'd1);

    // Restart in RECEIVE is ignored: next word still goes to addr 1.
    pulse_restart();
    send_word(32'hFFFFFFFF, 1);
    tick(3);
    chk("rcv-restart nwrites", 64'(q1.size()), 64'd2);
    chk_wr(1'b0, 1, 8'd1, 32'hFFFFFFFF);
    chk("rcv-restart count", 64'(cnt1), 64'd2);
    chk("rcv-restart done",  64'(dn1), 64'd1);

    // Restart from DONE clears and reloads from address 0.
    pulse_restart();
    chk("restart count",    64'(cnt1), 64'd0);
    chk("restart done",     64'(dn1), 64'd0);
    chk("restart overflow", 64'(ov1), 64'd0);
    q1.delete();
    send(8'hDE, 1);
    send(8'hAD, 1);
    pulse_restart();   // mid-word, must not disturb assembly
    send(8'hBE, 1);
    send(8'hEF, 1);
    send_word(32'hFFFFFFFF, 1);
    tick(3);
    chk("reload nwrites", 64'(q1.size()), 64'd2);
    chk_wr(1'b0, 0, 8'd0, 32'hDEADBEEF);
    chk_wr(1'b0, 1, 8'd1, 32'hFFFFFFFF);
    chk("reload count", 64'(cnt1), 64'd2);
    chk("reload done",  64'(dn1), 64'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
